control_sequencer: RTL and testbench

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

---
 rtl/cpu_ctl_pkg.sv | 111 +++++++++++
 rtl/mem_wait_cnt.sv | 17 +
 rtl/control_sequencer.sv | 121 ++++++++++++
 tb/tb_control_sequencer.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/cpu_ctl_pkg.sv
// cpu_ctl_pkg: opcodes, strobe bit map, state encoding and decode helpers; MUL_DIV_EN enables mul/div
package cpu_ctl_pkg;
  localparam logic [4:0] OP_LD   = 5'b00000;
  localparam logic [4:0] OP_LDI  = 5'b00001;
  localparam logic [4:0] OP_ST   = 5'b00010;
  localparam logic [4:0] OP_R_LO = 5'b00011;
  localparam logic [4:0] OP_R_HI = 5'b01011;
  localparam logic [4:0] OP_I_LO = 5'b01100;
  localparam logic [4:0] OP_I_HI = 5'b01110;
  localparam logic [4:0] OP_MUL  = 5'b01111;
  localparam logic [4:0] OP_DIV  = 5'b10000;
  localparam logic [4:0] OP_NEG  = 5'b10001;
  localparam logic [4:0] OP_NOT  = 5'b10010;
  localparam logic [4:0] OP_BR   = 5'b10011;
  localparam logic [4:0] OP_JR   = 5'b10100;
  localparam logic [4:0] OP_JAL  = 5'b10101;
  localparam logic [4:0] OP_IN   = 5'b10110;
  localparam logic [4:0] OP_OUT  = 5'b10111;
  localparam logic [4:0] OP_MFHI = 5'b11000;
  localparam logic [4:0] OP_MFLO = 5'b11001;
  localparam logic [4:0] OP_NOP  = 5'b11010;
  localparam logic [4:0] OP_HALT = 5'b11011;
  localparam logic [4:0] OP_ADD  = OP_R_LO;

  localparam int C_PCOUT     = 0;
  localparam int C_ZHIOUT    = 1;
  localparam int C_ZLOOUT    = 2;
  localparam int C_HIOUT     = 3;
  localparam int C_LOOUT     = 4;
  localparam int C_INPORTOUT = 5;
  localparam int C_COUT      = 6;
  localparam int C_MDROUT    = 7;
  localparam int C_MARIN     = 8;
  localparam int C_PCIN      = 9;
  localparam int C_MDRIN     = 10;
  localparam int C_IRIN      = 11;
  localparam int C_YIN       = 12;
  localparam int C_INCPC     = 13;
  localparam int C_READ      = 14;
  localparam int C_WRITE     = 15;
  localparam int C_HIIN      = 16;
  localparam int C_LOIN      = 17;
  localparam int C_ZHIIN     = 18;
  localparam int C_ZLOIN     = 19;
  localparam int C_CONIN     = 20;
  localparam int C_GRA       = 21;
  localparam int C_GRB       = 22;
  localparam int C_GRC       = 23;
  localparam int C_RIN       = 24;
  localparam int C_ROUT      = 25;
  localparam int C_BAOUT     = 26;
  localparam int C_JAL       = 27;
  localparam int C_OUTPORTIN = 28;
  localparam int N_CTL       = 29;

  typedef logic [N_CTL-1:0] ctl_t;

  typedef enum logic [5:0] {
    S_RST, S_T0, S_T1, S_T2,
    S_LD3, S_LD4, S_LD5, S_LD6, S_LD7, S_WB5, S_ST6, S_ST7,
    S_R3, S_R4, S_NEG3, S_NEG4,
    S_BR3, S_BR4, S_BR5, S_BR6, S_JR3, S_JAL3, S_JAL4, S_JAL5,
    S_IN3, S_OUT3, S_MFHI3, S_MFLO3,
    S_MD3, S_MD4, S_MD5, S_MD6, S_HALT
  } state_t;

  function automatic ctl_t cb(int i);
    return ctl_t'(1) << i;
  endfunction

  function automatic logic op_legal(logic [4:0] o);
`ifdef MUL_DIV_EN
    return o <= OP_HALT;
`else
    return o <= OP_HALT && o != OP_MUL && o != OP_DIV;
`endif
  endfunction

  // first execute state for an opcode; nop and undefined opcodes go straight back to fetch
  function automatic state_t first_step(logic [4:0] o);
    if (!op_legal(o)) return S_T0;
    if (o <= OP_ST) return S_LD3;
    if (o <= OP_I_HI) return S_R3;
    if (o <= OP_DIV) return S_MD3;
    if (o <= OP_NOT) return S_NEG3;
    case (o)
      OP_BR:   return S_BR3;
      OP_JR:   return S_JR3;
      OP_JAL:  return S_JAL3;
      OP_IN:   return S_IN3;
      OP_OUT:  return S_OUT3;
      OP_MFHI: return S_MFHI3;
      OP_MFLO: return S_MFLO3;
      OP_HALT: return S_HALT;
      default: return S_T0;
    endcase
  endfunction

  function automatic logic [3:0] t_step(state_t s);
    case (s)
      S_T1: return 4'd1;
      S_T2: return 4'd2;
      S_LD3, S_R3, S_NEG3, S_BR3, S_JR3, S_JAL3, S_IN3, S_OUT3, S_MFHI3, S_MFLO3, S_MD3: return 4'd3;
      S_LD4, S_R4, S_NEG4, S_BR4, S_JAL4, S_MD4: return 4'd4;
      S_LD5, S_WB5, S_BR5, S_JAL5, S_MD5: return 4'd5;
      S_LD6, S_ST6, S_BR6, S_MD6: return 4'd6;
      S_LD7, S_ST7: return 4'd7;
      default: return 4'd0;
    endcase
  endfunction
endpackage

// File: rtl/mem_wait_cnt.sv
// mem_wait_cnt: counts cycles spent in a memory-access state; done once MEM_WAIT extra cycles have elapsed
module mem_wait_cnt #(
  parameter int MEM_WAIT = 0
) (
  input  logic clk,
  input  logic clr,
  input  logic load,
  input  logic en,
  output logic done
);
  logic [2:0] r_cnt;
  // load restarts from zero outside memory states; count saturates at MEM_WAIT
  always_ff @(posedge clk)
    if (!clr || load) r_cnt <= '0;
    else if (en && !done) r_cnt <= r_cnt + 3'd1;
  assign done = (r_cnt == 3'(MEM_WAIT));
endmodule

// File: rtl/control_sequencer.sv
// control_sequencer: Moore T-step control unit driving datapath strobes; MUL_DIV_EN enables mul/div sequences
module control_sequencer
  import cpu_ctl_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int OPC_W    = 5,
  parameter int MEM_WAIT = 0
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [DATA_W-1:0] ir,
  input  logic              con_ff,
  output logic [N_CTL-1:0]  ctl,
  output logic [OPC_W-1:0]  alu_op,
  output logic              run,
  output logic              illegal,
  output logic [3:0]        tstate
);
  state_t           r_state, w_next;
  logic [OPC_W-1:0] r_opc;
  logic             r_ill;
  logic [OPC_W-1:0] w_opc;
  logic             w_mem, w_done, w_unused;

  assign w_opc    = ir[DATA_W-1 -: OPC_W];
  assign w_unused = ^ir[DATA_W-OPC_W-1:0];
  assign w_mem    = r_state == S_T1 || r_state == S_LD6 || r_state == S_ST7;
  assign illegal  = r_ill;

  mem_wait_cnt #(.MEM_WAIT(MEM_WAIT)) u_wait (
    .clk (clk),
    .clr (clr),
    .load(!w_mem),
    .en  (w_mem),
    .done(w_done)
  );

  // state register; opcode latched and legality judged as T2 is left
  always_ff @(posedge clk)
    if (!clr) begin
      r_state <= S_RST;
      r_opc   <= '0;
      r_ill   <= 1'b0;
    end else begin
      r_state <= w_next;
      r_ill   <= r_state == S_T2 && !op_legal(w_opc);
      if (r_state == S_T2) r_opc <= w_opc;
    end

  // next-state: memory states hold until the wait counter is done
  always_comb begin
    w_next = S_T0;
    case (r_state)
      S_RST:   w_next = S_T0;
      S_T0:    w_next = S_T1;
      S_T1:    w_next = w_done ? S_T2 : S_T1;
      S_T2:    w_next = first_step(w_opc);
      S_LD3:   w_next = S_LD4;
      S_LD4:   w_next = (r_opc == OP_LD || r_opc == OP_ST) ? S_LD5 : S_WB5;
      S_LD5:   w_next = (r_opc == OP_ST) ? S_ST6 : S_LD6;
      S_LD6:   w_next = w_done ? S_LD7 : S_LD6;
      S_ST6:   w_next = S_ST7;
      S_ST7:   w_next = w_done ? S_T0 : S_ST7;
      S_R3:    w_next = (r_opc >= OP_I_LO) ? S_LD4 : S_R4;
      S_R4:    w_next = S_WB5;
      S_NEG3:  w_next = S_NEG4;
      S_BR3:   w_next = S_BR4;
      S_BR4:   w_next = S_BR5;
      S_BR5:   w_next = S_BR6;
      S_JAL3:  w_next = S_JAL4;
      S_JAL4:  w_next = S_JAL5;
      S_MD3:   w_next = S_MD4;
      S_MD4:   w_next = S_MD5;
      S_MD5:   w_next = S_MD6;
      S_HALT:  w_next = S_HALT;
      default: w_next = S_T0;
    endcase
  end

  // Moore outputs decoded from the registered state; only br T6 looks at con_ff
  always_comb begin
    ctl    = '0;
    tstate = t_step(r_state);
    run    = r_state != S_HALT;
    alu_op = (r_state == S_T0) ? OPC_W'(OP_ADD) : (tstate >= 4'd3) ? r_opc : '0;
    case (r_state)
      S_T0:    ctl = cb(C_PCOUT) | cb(C_MARIN) | cb(C_INCPC) | cb(C_ZLOIN);
      S_T1:    ctl = cb(C_ZLOOUT) | cb(C_PCIN) | cb(C_READ) | cb(C_MDRIN);
      S_T2:    ctl = cb(C_MDROUT) | cb(C_IRIN);
      S_LD3:   ctl = cb(C_GRB) | cb(C_BAOUT) | cb(C_YIN);
      S_LD4:   ctl = cb(C_COUT) | cb(C_ZLOIN);
      S_LD5:   ctl = cb(C_ZLOOUT) | cb(C_MARIN);
      S_LD6:   ctl = cb(C_READ) | cb(C_MDRIN);
      S_LD7:   ctl = cb(C_MDROUT) | cb(C_GRA) | cb(C_RIN);
      S_WB5:   ctl = cb(C_ZLOOUT) | cb(C_GRA) | cb(C_RIN);
      S_ST6:   ctl = cb(C_GRA) | cb(C_ROUT) | cb(C_MDRIN);
      S_ST7:   ctl = cb(C_WRITE);
      S_R3:    ctl = cb(C_GRB) | cb(C_ROUT) | cb(C_YIN);
      S_R4:    ctl = cb(C_GRC) | cb(C_ROUT) | cb(C_ZLOIN);
      S_NEG3:  ctl = cb(C_GRB) | cb(C_ROUT) | cb(C_ZLOIN);
      S_NEG4:  ctl = cb(C_ZLOOUT) | cb(C_GRA) | cb(C_RIN);
      S_BR3:   ctl = cb(C_GRA) | cb(C_ROUT) | cb(C_CONIN);
      S_BR4:   ctl = cb(C_PCOUT) | cb(C_YIN);
      S_BR5:   ctl = cb(C_COUT) | cb(C_ZLOIN);
      S_BR6:   ctl = cb(C_ZLOOUT) | (con_ff ? cb(C_PCIN) : '0);
      S_JR3:   ctl = cb(C_GRA) | cb(C_ROUT) | cb(C_PCIN);
      S_JAL3:  ctl = cb(C_PCOUT) | cb(C_ZLOIN);
      S_JAL4:  ctl = cb(C_ZLOOUT) | cb(C_JAL);
      S_JAL5:  ctl = cb(C_GRA) | cb(C_ROUT) | cb(C_PCIN);
      S_IN3:   ctl = cb(C_INPORTOUT) | cb(C_GRA) | cb(C_RIN);
      S_OUT3:  ctl = cb(C_GRA) | cb(C_ROUT) | cb(C_OUTPORTIN);
      S_MFHI3: ctl = cb(C_HIOUT) | cb(C_GRA) | cb(C_RIN);
      S_MFLO3: ctl = cb(C_LOOUT) | cb(C_GRA) | cb(C_RIN);
      S_MD3:   ctl = cb(C_GRA) | cb(C_ROUT) | cb(C_YIN);
      S_MD4:   ctl = cb(C_GRB) | cb(C_ROUT) | cb(C_ZLOIN) | cb(C_ZHIIN);
      S_MD5:   ctl = cb(C_ZLOOUT) | cb(C_LOIN);
      S_MD6:   ctl = cb(C_ZHIOUT) | cb(C_HIIN);
      default: ctl = '0;
    endcase
  end
endmodule

// File: tb/tb_control_sequencer.sv
// tb_control_sequencer: randomized and directed checks of control_sequencer against a T-step table model
module tb_control_sequencer;
  import cpu_ctl_pkg::*;
  typedef logic [N_CTL-1:0] msk_t;

  logic clk = 0;
  always #5 clk = ~clk;

  logic             clr    [3];
  logic [31:0]      ir     [3];
  logic             con_ff [3];
  logic [N_CTL-1:0] ctl    [3];
  logic [4:0]       alu_op [3];
  logic             run    [3];
  logic             illegal[3];
  logic [3:0]       tstate [3];

  for (genvar g = 0; g < 3; g++) begin : g_dut
    control_sequencer #(.MEM_WAIT(g == 0 ? 0 : g == 1 ? 2 : 3)) u_dut (
      .clk    (clk),
      .clr    (clr[g]),
      .ir     (ir[g]),
      .con_ff (con_ff[g]),
      .ctl    (ctl[g]),
      .alu_op (alu_op[g]),
      .run    (run[g]),
      .illegal(illegal[g]),
      .tstate (tstate[g])
    );
  end

  int   n_tests = 0, n_fail = 0, act = -1, last_rd = 0;
  msk_t st_list[$];
  logic m_ill, m_halt;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s dut=%0d t=%0t: got %0h expected %0h", tag, act, $time, got, exp);
    end
  endtask

  function automatic msk_t sb(int i);
    return msk_t'(1) << i;
  endfunction

  // strobe set per T-step, straight from the instruction tables
  task automatic build(logic [4:0] o, logic c);
    msk_t a3 = sb(C_GRB) | sb(C_BAOUT) | sb(C_YIN);
    msk_t c4 = sb(C_COUT) | sb(C_ZLOIN);
    msk_t wb = sb(C_ZLOOUT) | sb(C_GRA) | sb(C_RIN);
    msk_t ry = sb(C_GRB) | sb(C_ROUT) | sb(C_YIN);
    msk_t mr = sb(C_ZLOOUT) | sb(C_MARIN);
    m_ill  = 0;
    m_halt = 0;
    st_list = {sb(C_PCOUT) | sb(C_MARIN) | sb(C_INCPC) | sb(C_ZLOIN),
               sb(C_ZLOOUT) | sb(C_PCIN) | sb(C_READ) | sb(C_MDRIN),
               sb(C_MDROUT) | sb(C_IRIN)};
    if (o == 0) st_list = {st_list, a3, c4, mr, sb(C_READ) | sb(C_MDRIN), sb(C_MDROUT) | sb(C_GRA) | sb(C_RIN)};
    else if (o == 1) st_list = {st_list, a3, c4, wb};
    else if (o == 2) st_list = {st_list, a3, c4, mr, sb(C_GRA) | sb(C_ROUT) | sb(C_MDRIN), sb(C_WRITE)};
    else if (o >= 3 && o <= 11) st_list = {st_list, ry, sb(C_GRC) | sb(C_ROUT) | sb(C_ZLOIN), wb};
    else if (o >= 12 && o <= 14) st_list = {st_list, ry, c4, wb};
    else if (o == 17 || o == 18) st_list = {st_list, sb(C_GRB) | sb(C_ROUT) | sb(C_ZLOIN), wb};
    else if (o == 19) st_list = {st_list, sb(C_GRA) | sb(C_ROUT) | sb(C_CONIN), sb(C_PCOUT) | sb(C_YIN), c4,
                                 sb(C_ZLOOUT) | (c ? sb(C_PCIN) : '0)};
    else if (o == 20) st_list = {st_list, sb(C_GRA) | sb(C_ROUT) | sb(C_PCIN)};
    else if (o == 21) st_list = {st_list, sb(C_PCOUT) | sb(C_ZLOIN), sb(C_ZLOOUT) | sb(C_JAL),
                                 sb(C_GRA) | sb(C_ROUT) | sb(C_PCIN)};
    else if (o == 22) st_list = {st_list, sb(C_INPORTOUT) | sb(C_GRA) | sb(C_RIN)};
    else if (o == 23) st_list = {st_list, sb(C_GRA) | sb(C_ROUT) | sb(C_OUTPORTIN)};
    else if (o == 24) st_list = {st_list, sb(C_HIOUT) | sb(C_GRA) | sb(C_RIN)};
    else if (o == 25) st_list = {st_list, sb(C_LOOUT) | sb(C_GRA) | sb(C_RIN)};
    else if (o == 27) m_halt = 1;
    else if (o != 26) m_ill = 1;
  endtask

  // reset entered at a falling edge; leaves the DUT showing fetch T0
  task automatic rst_dut(int d);
    clr[d] = 0;
    @(negedge clk);
    chk("rst_ctl", ctl[d], 0);
    chk("rst_run", run[d], 1);
    chk("rst_illegal", illegal[d], 0);
    chk("rst_tstate", tstate[d], 0);
    clr[d] = 1;
    @(negedge clk);
  endtask

  task automatic sel(int d);
    if (d != act) begin
      foreach (clr[i]) clr[i] = 0;
      act = d;
      rst_dut(d);
    end
  endtask

  // called with the DUT showing T0; walks every expected cycle of one instruction
  task automatic run_instr(int d, logic [4:0] o, logic c, int abort_at);
    int k = 0;
    int mw = d == 0 ? 0 : d == 1 ? 2 : 3;
    int n_rd = 0;
    build(o, c);
    ir[d] = {o, 27'($urandom)};
    con_ff[d] = c;
    foreach (st_list[t]) begin
      int reps = (st_list[t][C_READ] || st_list[t][C_WRITE]) ? mw + 1 : 1;
      for (int r = 0; r < reps; r++) begin
        if (k > 0) @(negedge clk);
        chk("tstate", tstate[d], t);
        chk("ctl", ctl[d], st_list[t]);
        chk("run", run[d], 1);
        if (k > 0) chk("illegal_low", illegal[d], 0);
        if (t == 0) chk("aluop_add", alu_op[d], 5'b00011);
        else if (t >= 3) chk("aluop_exec", alu_op[d], o);
        n_rd += int'(ctl[d][C_READ]);
        if (k == abort_at) begin
          rst_dut(d);
          return;
        end
        k++;
      end
    end
    last_rd = n_rd;
    @(negedge clk);
    if (m_halt) begin
      for (int i = 0; i < 3; i++) begin
        chk("halt_ctl", ctl[d], 0);
        chk("halt_run", run[d], 0);
        @(negedge clk);
      end
      rst_dut(d);
    end else begin
      chk("illegal_pulse", illegal[d], m_ill);
      chk("back_to_t0", tstate[d], 0);
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    foreach (clr[i]) begin
      clr[i] = 0;
      ir[i] = '0;
      con_ff[i] = 0;
    end
    sel(0);
    run_instr(0, 5'b00001, 0, -1);
    run_instr(0, 5'b10011, 0, -1);
    run_instr(0, 5'b10011, 1, -1);
    run_instr(0, 5'b10101, 0, -1);
    run_instr(0, 5'b11111, 0, -1);
    run_instr(0, 5'b01111, 0, -1);
    run_instr(0, 5'b10000, 1, -1);
    run_instr(0, 5'b11010, 0, -1);
    run_instr(0, 5'b11011, 0, -1);
    run_instr(0, 5'b00000, 0, -1);
    sel(1);
    run_instr(1, 5'b00000, 0, -1);
    chk("ld_read_cycles", last_rd, 6);
    run_instr(1, 5'b00010, 0, -1);
    sel(2);
    run_instr(2, 5'b00010, 0, 11);
    run_instr(2, 5'b11010, 0, -1);
    run_instr(2, 5'b00000, 1, -1);
    for (int i = 0; i < 80; i++) begin
      int d = int'($urandom_range(0, 2));
      sel(d);
      run_instr(d, 5'($urandom_range(0, 31)), 1'($urandom_range(0, 1)), -1);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
